// File: rtl/mac_tree_pkg.sv
// mac_tree_pkg: shared types and elaboration-time helpers for the mac_tree
// dot-product engine (tree depth, latency, per-level node counts/offsets).
package mac_tree_pkg;

  // Control tag that travels down the pipeline beside each data beat.
  typedef struct packed {
    logic valid;
    logic accumulate;
  } beat_tag_t;

  // Registered reduction levels needed to fold num_taps products plus the
  // external partial sum down to one node.
  function automatic int unsigned tree_depth(input int unsigned num_taps);
    int unsigned n;
    int unsigned d;
    n = num_taps + 1;
    d = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 1) begin
        n = (n + 1) / 2;
        d = d + 1;
      end
    end
    return d;
  endfunction

  // Cycles from input sample to out_valid: leaf stage + tree + accumulator.
  function automatic int unsigned latency(input int unsigned num_taps);
    return tree_depth(num_taps) + 2;
  endfunction

  // Node count at tree level lvl (level 0 = leaves).
  function automatic int unsigned level_nodes(input int unsigned leaves,
                                              input int unsigned lvl);
    int unsigned n;
    n = leaves;
    for (int unsigned j = 0; j < lvl; j++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // Total nodes in all levels below lvl; used to pack levels into one bus.
  function automatic int unsigned level_offset(input int unsigned leaves,
                                               input int unsigned lvl);
    int unsigned s;
    s = 0;
    for (int unsigned j = 0; j < lvl; j++) begin
      s = s + level_nodes(leaves, j);
    end
    return s;
  endfunction

endpackage

// File: rtl/mac_tree_level.sv
// mac_tree_level: one registered level of the binary adder tree.
// Adjacent input nodes are summed pairwise in index order; an odd last node
// is registered unchanged.
//   clk      : rising-edge clock
//   arst_in  : asynchronous active-high reset, clears the level registers
//   din      : N_IN packed nodes of W bits, node i at [i*W +: W]
//   dout     : ceil(N_IN/2) packed registered nodes
module mac_tree_level #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned W    = 32
) (
  input  logic                          clk,
  input  logic                          arst_in,
  input  logic [N_IN*W-1:0]             din,
  output logic [((N_IN+1)/2)*W-1:0]     dout
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;

  wire [N_OUT*W-1:0] node_d;

  // Pairwise sums; wraps modulo 2^W.
  for (genvar i = 0; i < N_OUT; i++) begin : g_node
    if (2*i + 1 < N_IN) begin : g_pair
      assign node_d[i*W +: W] = din[(2*i)*W +: W] + din[(2*i+1)*W +: W];
    end else begin : g_pass
      assign node_d[i*W +: W] = din[(2*i)*W +: W];
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      dout <= '0;
    end else begin
      dout <= node_d;
    end
  end

endmodule

// File: rtl/mac_tree.sv
// mac_tree: pipelined signed multiply-accumulate dot-product engine.
// NUM_TAPS products plus partial_sum_in are reduced by a registered binary
// adder tree; a final stage accumulates or restarts on each valid beat.
// Optional macro MAC_TREE_SATURATE_EN clamps the scaled output to
// OUTPUT_WIDTH signed range and reports clipping on sat_flag.
//   clk            : rising-edge clock
//   arst_in        : asynchronous active-high reset
//   input_valid    : beat on a_in/b_in/partial_sum_in is valid
//   accumulate_in  : add to accumulator (1) or restart it (0)
//   partial_sum_in : signed external addend
//   a_in, b_in     : packed signed operands, tap i at [i*WIDTH +: WIDTH]
//   out            : scaled accumulator (combinational from acc)
//   out_valid      : registered, out carries a new result this cycle
//   sat_flag       : out was clipped this cycle (0 without saturation)
module mac_tree
  import mac_tree_pkg::*;
#(
  parameter int unsigned NUM_TAPS          = 9,
  parameter int unsigned A_WIDTH           = 16,
  parameter int unsigned B_WIDTH           = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH      = 16,
  parameter int unsigned OUTPUT_SCALE      = 0
) (
  input  logic                          clk,
  input  logic                          arst_in,
  input  logic                          input_valid,
  input  logic                          accumulate_in,
  input  logic [ACCUMULATOR_WIDTH-1:0]  partial_sum_in,
  input  logic [NUM_TAPS*A_WIDTH-1:0]   a_in,
  input  logic [NUM_TAPS*B_WIDTH-1:0]   b_in,
  output logic [OUTPUT_WIDTH-1:0]       out,
  output logic                          out_valid,
  output logic                          sat_flag
);

  localparam int unsigned AW        = ACCUMULATOR_WIDTH;
  localparam int unsigned LEAVES    = NUM_TAPS + 1;
  localparam int unsigned DEPTH     = tree_depth(NUM_TAPS);
  // Tree levels 1..DEPTH packed back to back; leaves live in leaf_q.
  localparam int unsigned TREE_BITS = (level_offset(LEAVES, DEPTH + 1) - LEAVES) * AW;
  localparam int unsigned FINAL_LO  = (level_offset(LEAVES, DEPTH) - LEAVES) * AW;

  logic [LEAVES*AW-1:0] leaf_d;
  logic [LEAVES*AW-1:0] leaf_q;
  wire  [TREE_BITS-1:0] tree_bus;
  beat_tag_t            tag_in;
  beat_tag_t [DEPTH:0]  tag_q;
  logic signed [AW-1:0] acc_q;
  logic                 out_valid_q;
  logic [AW-1:0]        tree_sum;
  logic signed [AW-1:0] acc_shifted;

  // Leaf products: operands sign-extended to AW so the product wraps mod 2^AW.
  always_comb begin
    leaf_d = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      leaf_d[i*AW +: AW] = AW'($signed(a_in[i*A_WIDTH +: A_WIDTH]))
                         * AW'($signed(b_in[i*B_WIDTH +: B_WIDTH]));
    end
    leaf_d[NUM_TAPS*AW +: AW] = partial_sum_in;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      leaf_q <= '0;
    end else begin
      leaf_q <= leaf_d;
    end
  end

  // Reduction tree, one registered level per iteration.
  for (genvar k = 0; k < DEPTH; k++) begin : g_level
    localparam int unsigned N_IN   = level_nodes(LEAVES, k);
    localparam int unsigned N_OUT  = level_nodes(LEAVES, k + 1);
    localparam int unsigned OUT_LO = (level_offset(LEAVES, k + 1) - LEAVES) * AW;

    logic [N_IN*AW-1:0] lvl_in;

    if (k == 0) begin : g_first
      assign lvl_in = leaf_q;
    end else begin : g_inner
      assign lvl_in = tree_bus[(level_offset(LEAVES, k) - LEAVES)*AW +: N_IN*AW];
    end

    mac_tree_level #(
      .N_IN (N_IN),
      .W    (AW)
    ) u_level (
      .clk     (clk),
      .arst_in (arst_in),
      .din     (lvl_in),
      .dout    (tree_bus[OUT_LO +: N_OUT*AW])
    );
  end

  assign tree_sum = tree_bus[FINAL_LO +: AW];

  // Tag shift register keeps valid/accumulate aligned with the tree data.
  assign tag_in = '{valid: input_valid, accumulate: accumulate_in};

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[DEPTH-1:0], tag_in};
    end
  end

  // Accumulator: single-cycle feedback, so back-to-back beats see each other.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= tag_q[DEPTH].valid;
      if (tag_q[DEPTH].valid) begin
        acc_q <= tree_sum + (tag_q[DEPTH].accumulate ? acc_q : '0);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign acc_shifted = acc_q >>> OUTPUT_SCALE;

`ifdef MAC_TREE_SATURATE_EN
  localparam longint SAT_MAX = (64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1;
  localparam longint SAT_MIN = -(64'sd1 <<< (OUTPUT_WIDTH - 1));

  longint                  shifted_wide;
  logic [OUTPUT_WIDTH-1:0] out_c;
  logic                    clip_c;

  // Clamp the scaled accumulator into the signed output range.
  always_comb begin
    shifted_wide = 64'(acc_shifted);
    out_c        = OUTPUT_WIDTH'(acc_shifted);
    clip_c       = 1'b0;
    if (shifted_wide > SAT_MAX) begin
      out_c  = OUTPUT_WIDTH'(SAT_MAX);
      clip_c = 1'b1;
    end else if (shifted_wide < SAT_MIN) begin
      out_c  = OUTPUT_WIDTH'(SAT_MIN);
      clip_c = 1'b1;
    end
  end

  assign out      = out_c;
  assign sat_flag = clip_c;
`else
  assign out      = OUTPUT_WIDTH'(acc_shifted);
  assign sat_flag = 1'b0;
`endif

endmodule
